// File: rtl/mul_fp_pipe_param.sv
// Three-stage pipelined floating-point multiplier (unpack, multiply, round/pack) with valid/ack flow control.
// Optional status flags are compiled in when MUL_FLAGS_EN is defined.
module mul_fp_pipe_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*W-1:0] input_mul,
  input  logic           input_mul_stb,
  output logic           s_input_mul_ack,
  output logic [W-1:0]   z,
  output logic           s_output_z_stb,
  input  logic           output_z_ack
`ifdef MUL_FLAGS_EN
  ,
  output logic [3:0]     z_flags
`endif
);

  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int PW   = 2*MAN_W + 2;
  localparam int EW   = EXP_W + 2;
  localparam logic signed [EW-1:0] EMAX  = EW'(2**EXP_W - 1);
  localparam logic signed [EW-1:0] EZERO = '0;

  typedef enum logic [1:0] {CLS_NORM, CLS_NAN, CLS_INF, CLS_ZERO} cls_t;

  logic                   r_s1_valid, r_s1_sign;
  cls_t                   r_s1_cls;
  logic [EXP_W-1:0]       r_s1_ea, r_s1_eb;
  logic [MAN_W-1:0]       r_s1_ma, r_s1_mb;
  logic                   r_s2_valid, r_s2_sign;
  cls_t                   r_s2_cls;
  logic [PW-1:0]          r_s2_prod;
  logic signed [EW-1:0]   r_s2_exp;
  logic [W-1:0]           r_z;
  logic                   r_z_stb;

  logic w_s1_ready, w_s2_ready, w_s3_ready, w_in_fire;

  // A stage can take new data when empty or when its contents move on this cycle.
  assign w_s3_ready      = !r_z_stb || output_z_ack;
  assign w_s2_ready      = !r_s2_valid || w_s3_ready;
  assign w_s1_ready      = !r_s1_valid || w_s2_ready;
  assign s_input_mul_ack = !rst && w_s1_ready;
  assign w_in_fire       = input_mul_stb && s_input_mul_ack;
  assign z               = r_z;
  assign s_output_z_stb  = r_z_stb;

  // Stage 1 classification
  logic             w_a_s, w_b_s;
  logic [EXP_W-1:0] w_a_e, w_b_e;
  logic [MAN_W-1:0] w_a_m, w_b_m;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  cls_t             w_cls;

  assign {w_a_s, w_a_e, w_a_m} = input_mul[2*W-1:W];
  assign {w_b_s, w_b_e, w_b_m} = input_mul[W-1:0];
  assign w_a_zero = (w_a_e == '0);
  assign w_b_zero = (w_b_e == '0);
  assign w_a_nan  = (&w_a_e) && (|w_a_m);
  assign w_b_nan  = (&w_b_e) && (|w_b_m);
  assign w_a_inf  = (&w_a_e) && !(|w_a_m);
  assign w_b_inf  = (&w_b_e) && !(|w_b_m);

  always_comb begin
    w_cls = CLS_NORM;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      w_cls = CLS_NAN;
    else if (w_a_inf || w_b_inf)
      w_cls = CLS_INF;
    else if (w_a_zero || w_b_zero)
      w_cls = CLS_ZERO;
  end

  // Stage 2 datapath
  logic [PW-1:0]        w_s2_prod;
  logic signed [EW-1:0] w_s2_exp;

  assign w_s2_prod = PW'({1'b1, r_s1_ma}) * PW'({1'b1, r_s1_mb});
  assign w_s2_exp  = EW'(r_s1_ea) + EW'(r_s1_eb) - EW'(BIAS);

  // Stage 3 normalise, round to nearest even, pack
  logic                 w_norm, w_guard, w_sticky, w_round_up, w_carry, w_ovf, w_unf;
  logic [2*MAN_W-1:0]   w_sh;
  logic [MAN_W-1:0]     w_man, w_man_r;
  logic signed [EW-1:0] w_exp_n, w_exp_r;
  logic [W-1:0]         w_z;

  always_comb begin
    w_norm     = r_s2_prod[PW-1];
    w_sh       = w_norm ? r_s2_prod[2*MAN_W:1] : r_s2_prod[2*MAN_W-1:0];
    w_man      = w_sh[2*MAN_W-1:MAN_W];
    w_guard    = w_sh[MAN_W-1];
    w_sticky   = (|w_sh[MAN_W-2:0]) || (w_norm && r_s2_prod[0]);
    w_exp_n    = r_s2_exp + EW'(w_norm);
    w_round_up = w_guard && (w_sticky || w_man[0]);
    {w_carry, w_man_r} = {1'b0, w_man} + (MAN_W+1)'(w_round_up);
    w_exp_r    = w_exp_n + EW'(w_carry);
    w_ovf      = (w_exp_r >= EMAX);
    w_unf      = (w_exp_r <= EZERO);
    w_z        = '0;
    case (r_s2_cls)
      CLS_NAN:  w_z = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      CLS_INF:  w_z = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: w_z = {r_s2_sign, {(W-1){1'b0}}};
      default: begin
        if (w_ovf)
          w_z = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (w_unf)
          w_z = {r_s2_sign, {(W-1){1'b0}}};
        else
          w_z = {r_s2_sign, w_exp_r[EXP_W-1:0], w_man_r};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_cls   <= CLS_NORM;
      r_s1_ea    <= '0;
      r_s1_eb    <= '0;
      r_s1_ma    <= '0;
      r_s1_mb    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_cls   <= CLS_NORM;
      r_s2_prod  <= '0;
      r_s2_exp   <= '0;
      r_z        <= '0;
      r_z_stb    <= 1'b0;
    end else begin
      if (w_s1_ready) begin
        r_s1_valid <= w_in_fire;
        if (w_in_fire) begin
          r_s1_sign <= w_a_s ^ w_b_s;
          r_s1_cls  <= w_cls;
          r_s1_ea   <= w_a_e;
          r_s1_eb   <= w_b_e;
          r_s1_ma   <= w_a_m;
          r_s1_mb   <= w_b_m;
        end
      end
      if (w_s2_ready) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_sign <= r_s1_sign;
          r_s2_cls  <= r_s1_cls;
          r_s2_prod <= w_s2_prod;
          r_s2_exp  <= w_s2_exp;
        end
      end
      if (w_s3_ready) begin
        r_z_stb <= r_s2_valid;
        if (r_s2_valid)
          r_z <= w_z;
      end
    end
  end

`ifdef MUL_FLAGS_EN
  // {invalid, overflow, underflow, inexact}, loaded together with z
  logic [3:0] w_flags, r_flags;

  always_comb begin
    w_flags = '0;
    case (r_s2_cls)
      CLS_NAN:  w_flags = 4'b1000;
      CLS_NORM: w_flags = {1'b0, w_ovf, w_unf && !w_ovf, w_guard || w_sticky || w_ovf || w_unf};
      default:  w_flags = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_flags <= '0;
    else if (w_s3_ready && r_s2_valid)
      r_flags <= w_flags;
  end

  assign z_flags = r_flags;
`endif

endmodule
